clock_display_scheduler: RTL
============================

CLOCK_DISPLAY_SCHEDULER -- requirements
Module: clock_display_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each digit position is held (legal range 2..1024).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 tick_1hz  input  1  one-cycle pulse per elapsed second.
REQ-005 ny_day  input  1  high while calendar date is Dec 31.
REQ-006 set_valid  input  1  time-load request; held high until set_ready seen.
REQ-007 set_hour  input  5  binary hour to load, legal 0..23.
REQ-008 set_min  input  6  binary minute to load, legal 0..59.
REQ-009 set_ready  output  1  load accepted this cycle when set_valid also high.
REQ-010 set_err  output  1  one-cycle pulse: accepted load was out of range and ignored.
REQ-011 digit_out  output  4  BCD digit for the currently scanned position.
REQ-012 digit_sel  output  4  one-hot position select: bit0 minute-ones, bit1 minute-tens, bit2 hour-ones, bit3 hour-tens.
REQ-013 second_digit  output  1  high while digit_sel selects position 0 (minute-ones).
REQ-014 ny_countdown  output  1  high during the final ten minutes of Dec 31.
REQ-015 new_year  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover while ny_day=1.

Function
REQ-016 Internal time SHALL be binary hour 0..23, minute 0..59 and second 0..59; all outputs SHALL be registered.
REQ-017 On tick_1hz: second SHALL increment; 59 wraps to 0 and carries to minute; minute 59 wraps to 0 and carries to hour; hour 23 wraps to 0.
REQ-018 new_year SHALL assert the cycle after a tick rolls 23:59:59 to 00:00:00 with ny_day=1, for exactly one cycle.
REQ-019 ny_countdown SHALL equal registered (ny_day AND hour==23 AND minute>=50), updated one cycle after the time change.
REQ-020 Load FSM states: IDLE, LOAD, HOLD.
REQ-021 IDLE: set_ready=1; set_valid=1 moves to LOAD (handshake completes in that cycle).
REQ-022 LOAD (1 cycle): set_ready=0; if set_hour<=23 and set_min<=59, write hour/minute and clear second to 0; otherwise keep time and pulse set_err; next state HOLD.
REQ-023 HOLD: set_ready=0; stay while set_valid=1; return to IDLE the cycle after set_valid=0.
REQ-024 A tick_1hz coinciding with the LOAD cycle SHALL be dropped; a tick in any other state SHALL be applied.
REQ-025 Load operands SHALL be sampled in the IDLE handshake cycle; later changes are ignored.
REQ-026 Scan counter SHALL count 0..SCAN_DIV-1; on wrap, digit_sel SHALL rotate 0001->0010->0100->1000->0001.
REQ-027 digit_out SHALL be the BCD digit of the position selected by digit_sel in the same cycle, derived from current time (binary-to-BCD, values 0..9 only; hour-tens 0..2, minute-tens 0..5).
REQ-028 While ny_countdown=1, digit_out SHALL be minute-ones at position 0 and 0 at positions 1..3.
REQ-029 Scanning SHALL run continuously and independently of the load FSM and ticks.

Reset
REQ-030 RST=1 at a clock edge SHALL force time 00:00:00, FSM IDLE, scan counter 0, digit_sel=0001, digit_out=0, second_digit=1, ny_countdown=0, new_year=0, set_err=0, set_ready=0.
REQ-031 set_ready SHALL first assert the cycle after RST deasserts; RST during LOAD/HOLD SHALL abort the load without changing time beyond reset values.
REQ-032 RST SHALL override tick_1hz and set_valid in the same cycle.

Verification
REQ-033 Load 23/59, 60 ticks with ny_day=1 -> time 00:00:00, new_year one-cycle pulse, ny_countdown falls 1->0.
REQ-034 Load 23/49, ny_day=1, 60 ticks -> ny_countdown rises when minute becomes 50; digit_out=0 at positions 1..3 thereafter.
REQ-035 set_valid with set_hour=24, set_min=10 -> set_err pulse, time unchanged, set_ready low until set_valid drops, then high.
REQ-036 tick_1hz asserted in LOAD cycle of load 12/34 -> time 12:34:00 (tick dropped); next tick -> 12:34:01.
REQ-037 SCAN_DIV=4, time 17:05 -> digit_sel/digit_out sequence 0001/5, 0010/0, 0100/7, 1000/1, each 4 cycles, repeating.
REQ-038 RST asserted during HOLD -> all outputs at REQ-030 values next cycle, set_ready=1 the cycle after RST deasserts.

Source files
------------

// File: rtl/clock_display_scheduler_if.sv
// Time-load handshake bundle for clock_display_scheduler.
// The master side (host) requests a load; the slave side (scheduler)
// answers with set_ready and reports rejected loads on set_err.
interface clock_display_scheduler_if;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       set_ready;
    logic       set_err;

    modport master (
        output set_valid,
        output set_hour,
        output set_min,
        input  set_ready,
        input  set_err
    );

    modport slave (
        input  set_valid,
        input  set_hour,
        input  set_min,
        output set_ready,
        output set_err
    );
endinterface

// File: rtl/clock_display_scheduler.sv
// Clock display scheduler: keeps hh:mm:ss time advanced by a 1 Hz tick,
// accepts time loads over a ready/valid handshake, multiplexes four BCD
// digits onto a scanned display and flags the New Year countdown/rollover.
// Every output comes straight from a flop.
module clock_display_scheduler #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            tick_1hz,
    input  logic                            ny_day,
    clock_display_scheduler_if.slave        set_if,
    output logic [3:0]                      digit_out,
    output logic [3:0]                      digit_sel,
    output logic                            second_digit,
    output logic                            ny_countdown,
    output logic                            new_year
);

    localparam int unsigned     CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Binary 0..59 to packed BCD {tens, ones}; hours reuse it zero-extended.
    function automatic logic [7:0] to_bcd(input logic [5:0] bin);
        logic [3:0] tens;
        logic [5:0] sub;
        if (bin >= 6'd50) begin
            tens = 4'd5;
            sub  = 6'd50;
        end else if (bin >= 6'd40) begin
            tens = 4'd4;
            sub  = 6'd40;
        end else if (bin >= 6'd30) begin
            tens = 4'd3;
            sub  = 6'd30;
        end else if (bin >= 6'd20) begin
            tens = 4'd2;
            sub  = 6'd20;
        end else if (bin >= 6'd10) begin
            tens = 4'd1;
            sub  = 6'd10;
        end else begin
            tens = 4'd0;
            sub  = 6'd0;
        end
        return {tens, 4'(bin - sub)};
    endfunction

    // ------------------------------------------------------------------
    // State and output flops
    // ------------------------------------------------------------------
    state_t            state_q,        state_d;
    logic [4:0]        hour_q,         hour_d;
    logic [5:0]        min_q,          min_d;
    logic [5:0]        sec_q,          sec_d;
    logic [4:0]        ld_hour_q,      ld_hour_d;
    logic [5:0]        ld_min_q,       ld_min_d;
    logic [CNT_W-1:0]  scan_cnt_q,     scan_cnt_d;
    logic [3:0]        digit_sel_q,    digit_sel_d;
    logic [3:0]        digit_out_q,    digit_out_d;
    logic              second_digit_q, second_digit_d;
    logic              ny_countdown_q, ny_countdown_d;
    logic              new_year_q,     new_year_d;
    logic              set_ready_q,    set_ready_d;
    logic              set_err_q,      set_err_d;

    // Combinational helpers
    logic              accept_s;
    logic              tick_apply_s;
    logic              ld_ok_s;
    logic              rollover_s;
    logic              scan_wrap_s;
    logic [7:0]        min_bcd_s;
    logic [7:0]        hour_bcd_s;

    // Handshake acceptance, tick gating and load range check
    always_comb begin
        accept_s     = (state_q == ST_IDLE) && set_ready_q && set_if.set_valid;
        // The LOAD cycle owns the time registers, so a tick landing there is lost.
        tick_apply_s = tick_1hz && (state_q != ST_LOAD);
        ld_ok_s      = (ld_hour_q <= 5'd23) && (ld_min_q <= 6'd59);
        rollover_s   = tick_apply_s && (hour_q == 5'd23) && (min_q == 6'd59)
                       && (sec_q == 6'd59);
    end

    // Load FSM next state, operand capture and the set_ready/set_err outputs
    always_comb begin
        state_d   = state_q;
        ld_hour_d = ld_hour_q;
        ld_min_d  = ld_min_q;
        set_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_LOAD;
                    // Operands are frozen here; later bus changes are ignored.
                    ld_hour_d = set_if.set_hour;
                    ld_min_d  = set_if.set_min;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
                if (ld_ok_s) begin
                    set_err_d = 1'b0;
                end else begin
                    set_err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (set_if.set_valid) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        set_ready_d = (state_d == ST_IDLE);
    end

    // Timekeeping: a valid load overwrites hh:mm and zeroes seconds, otherwise ticks count
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if ((state_q == ST_LOAD) && ld_ok_s) begin
            hour_d = ld_hour_q;
            min_d  = ld_min_q;
            sec_d  = 6'd0;
        end else if (tick_apply_s) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    if (hour_q == 5'd23) begin
                        hour_d = 5'd0;
                    end else begin
                        hour_d = hour_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            hour_d = hour_q;
            min_d  = min_q;
            sec_d  = sec_q;
        end
    end

    // New Year flags: countdown follows the current time one cycle late, rollover pulses once
    always_comb begin
        ny_countdown_d = ny_day && (hour_q == 5'd23) && (min_q >= 6'd50);
        new_year_d     = rollover_s && ny_day;
    end

    // Free-running digit scan and the digit shown at the selected position
    always_comb begin
        scan_wrap_s = (scan_cnt_q == CNT_LAST);
        if (scan_wrap_s) begin
            scan_cnt_d  = '0;
            digit_sel_d = {digit_sel_q[2:0], digit_sel_q[3]};
        end else begin
            scan_cnt_d  = scan_cnt_q + CNT_W'(1);
            digit_sel_d = digit_sel_q;
        end
        second_digit_d = digit_sel_d[0];

        // Digits follow the time that will be held next to them in the same cycle.
        min_bcd_s  = to_bcd(min_d);
        hour_bcd_s = to_bcd({1'b0, hour_d});
        case (digit_sel_d)
            4'b0001: digit_out_d = min_bcd_s[3:0];
            4'b0010: digit_out_d = ny_countdown_d ? 4'd0 : min_bcd_s[7:4];
            4'b0100: digit_out_d = ny_countdown_d ? 4'd0 : hour_bcd_s[3:0];
            4'b1000: digit_out_d = ny_countdown_d ? 4'd0 : hour_bcd_s[7:4];
            default: digit_out_d = 4'd0;
        endcase
    end

    // Register all state and outputs; RST forces the power-on values
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            hour_q         <= 5'd0;
            min_q          <= 6'd0;
            sec_q          <= 6'd0;
            ld_hour_q      <= 5'd0;
            ld_min_q       <= 6'd0;
            scan_cnt_q     <= '0;
            digit_sel_q    <= 4'b0001;
            digit_out_q    <= 4'd0;
            second_digit_q <= 1'b1;
            ny_countdown_q <= 1'b0;
            new_year_q     <= 1'b0;
            set_ready_q    <= 1'b0;
            set_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hour_q         <= hour_d;
            min_q          <= min_d;
            sec_q          <= sec_d;
            ld_hour_q      <= ld_hour_d;
            ld_min_q       <= ld_min_d;
            scan_cnt_q     <= scan_cnt_d;
            digit_sel_q    <= digit_sel_d;
            digit_out_q    <= digit_out_d;
            second_digit_q <= second_digit_d;
            ny_countdown_q <= ny_countdown_d;
            new_year_q     <= new_year_d;
            set_ready_q    <= set_ready_d;
            set_err_q      <= set_err_d;
        end
    end

    assign digit_out        = digit_out_q;
    assign digit_sel        = digit_sel_q;
    assign second_digit     = second_digit_q;
    assign ny_countdown     = ny_countdown_q;
    assign new_year         = new_year_q;
    assign set_if.set_ready = set_ready_q;
    assign set_if.set_err   = set_err_q;

endmodule
